// File: rtl/btn_debounce_en.sv
// Push-button conditioner: 2-flop synchronizer, debounce FSM, and a registered
// single-cycle count enable with optional auto-repeat while the button is held.
module btn_debounce_en #(
  parameter int DB_CYCLES  = 8,
  parameter int REP_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic en_pulse,
  output logic btn_level
);

  localparam logic [3:0] DB_LAST  = 4'(DB_CYCLES - 1);
  localparam bit         REP_EN   = (REP_CYCLES != 0);
  localparam logic [5:0] REP_LAST = REP_EN ? 6'(REP_CYCLES - 1) : 6'd0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHK_HI = 2'd1,
    HIGH   = 2'd2,
    CHK_LO = 2'd3
  } state_t;

  logic       r_s1;
  logic       r_s2;
  state_t     r_state;
  logic [3:0] r_db_cnt;
  logic [5:0] r_rep_cnt;
  logic       r_en_pulse;
  logic       r_btn_level;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= btn_in;
      r_s2 <= r_s1;
    end
  end

  // Every decision below looks only at r_s2; r_s1 may still be metastable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_db_cnt    <= 4'd0;
      r_rep_cnt   <= 6'd0;
      r_en_pulse  <= 1'b0;
      r_btn_level <= 1'b0;
    end else begin
      r_en_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_s2) begin
            r_state  <= CHK_HI;
            r_db_cnt <= 4'd0;
          end
        end
        CHK_HI: begin
          if (!r_s2) begin
            r_state  <= IDLE;
            r_db_cnt <= 4'd0;
          end else if (r_db_cnt == DB_LAST) begin
            r_state     <= HIGH;
            r_db_cnt    <= 4'd0;
            r_rep_cnt   <= 6'd0;
            r_en_pulse  <= 1'b1;
            r_btn_level <= 1'b1;
          end else begin
            r_db_cnt <= r_db_cnt + 4'd1;
          end
        end
        HIGH: begin
          if (!r_s2) begin
            r_state  <= CHK_LO;
            r_db_cnt <= 4'd0;
          end else if (REP_EN) begin
            if (r_rep_cnt == REP_LAST) begin
              r_rep_cnt  <= 6'd0;
              r_en_pulse <= 1'b1;
            end else begin
              r_rep_cnt <= r_rep_cnt + 6'd1;
            end
          end
        end
        CHK_LO: begin
          // A bounce back high restarts the repeat period but never pulses.
          if (r_s2) begin
            r_state   <= HIGH;
            r_db_cnt  <= 4'd0;
            r_rep_cnt <= 6'd0;
          end else if (r_db_cnt == DB_LAST) begin
            r_state     <= IDLE;
            r_db_cnt    <= 4'd0;
            r_btn_level <= 1'b0;
          end else begin
            r_db_cnt <= r_db_cnt + 4'd1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign en_pulse  = r_en_pulse;
  assign btn_level = r_btn_level;

endmodule

// File: tb/tb_btn_debounce_en.sv
// Directed bench for btn_debounce_en: one instance with auto-repeat (32) and
// one with repeat disabled, driven from the same button and reset.
module tb_btn_debounce_en;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in = 1'b0;
  logic en_a, lvl_a, en_b, lvl_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_a    = 0;
  int cnt_b    = 0;

  btn_debounce_en #(.DB_CYCLES(8), .REP_CYCLES(32)) dut_a (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (btn_in),
    .en_pulse (en_a),
    .btn_level(lvl_a)
  );

  btn_debounce_en #(.DB_CYCLES(8), .REP_CYCLES(0)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (btn_in),
    .en_pulse (en_b),
    .btn_level(lvl_b)
  );

  always #5 clk = ~clk;

  // Advance past one posedge; outputs then show the cycle after that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int cyc, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int cyc, input logic exp_pa,
                           input logic exp_pb, input logic exp_lvl);
    check({tag, "_a_pulse"}, cyc, {31'd0, en_a}, {31'd0, exp_pa});
    check({tag, "_a_level"}, cyc, {31'd0, lvl_a}, {31'd0, exp_lvl});
    check({tag, "_b_pulse"}, cyc, {31'd0, en_b}, {31'd0, exp_pb});
    check({tag, "_b_level"}, cyc, {31'd0, lvl_b}, {31'd0, exp_lvl});
  endtask

  initial begin
    // Reset held with the button pressed: outputs stay low.
    btn_in = 1'b1;
    rst    = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_all("in_reset", i, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      check_all("post_reset_press", i, i == 11, i == 11, i >= 11);
    end
    $display("step reset-held-press done");

    // Release: level falls after release posedge 11, never a pulse.
    btn_in = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      check_all("release", i, 1'b0, 1'b0, i <= 10);
    end
    $display("step release done");

    // Clean press held 100 cycles past HIGH entry (posedge 11), then released.
    for (int i = 1; i <= 125; i++) begin
      btn_in = (i <= 111);
      tick();
      cnt_a += int'(en_a);
      cnt_b += int'(en_b);
      check_all("press_repeat", i, (i == 11) || (i == 43) || (i == 75) || (i == 107),
                i == 11, (i >= 11) && (i <= 121));
    end
    check("repeat_count_a", 125, 32'(cnt_a), 32'd4);
    check("repeat_count_b", 125, 32'(cnt_b), 32'd1);
    $display("step press/auto-repeat done");

    // Press bounce: high 5, low 2, high 4, then low.
    for (int i = 1; i <= 25; i++) begin
      btn_in = (i <= 5) || ((i >= 8) && (i <= 11));
      tick();
      check_all("press_bounce", i, 1'b0, 1'b0, 1'b0);
    end
    $display("step press-bounce done");

    // Release bounce at posedges 21..23; HIGH re-entered at posedge 26.
    for (int i = 1; i <= 75; i++) begin
      btn_in = (i <= 20) || ((i >= 24) && (i <= 60));
      tick();
      check_all("release_bounce", i, (i == 11) || (i == 58), i == 11,
                (i >= 11) && (i <= 70));
    end
    $display("step release-bounce done");

    // Reset sampled at posedge 32 while rep_cnt is 20; button stays held.
    for (int i = 1; i <= 50; i++) begin
      btn_in = 1'b1;
      rst    = (i == 32);
      tick();
      check_all("reset_mid_repeat", i, (i == 11) || (i == 43), (i == 11) || (i == 43),
                ((i >= 11) && (i <= 31)) || (i >= 43));
    end
    $display("step reset-mid-repeat done");

    btn_in = 1'b0;
    rst    = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      tick();
      check_all("final_reset", i, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_debounce_en.md
BTN_DEBOUNCE_EN -- requirements
Module: btn_debounce_en

Purpose: upstream stage of the 4-bit counter. Turns a raw, bouncing push-button into a clean single-cycle count enable, with optional auto-repeat while the button is held.

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter DB_CYCLES, default 8: consecutive stable samples needed to accept a level change, legal range 2..15.
REQ-002 The block SHALL have parameter REP_CYCLES, default 32: auto-repeat period in cycles while held, legal range 2..63; 0 disables repeat.

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clk, input, 1: clock, posedge active.
REQ-004 The block SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 The block SHALL have port btn_in, input, 1: raw asynchronous button level, 1 = pressed.
REQ-006 The block SHALL have port en_pulse, output, 1: registered single-cycle count enable to the downstream counter.
REQ-007 The block SHALL have port btn_level, output, 1: registered debounced button level.

Function
REQ-008 btn_in SHALL pass through a 2-flop synchronizer (s1 then s2); all FSM decisions SHALL use s2 only.
REQ-009 The FSM SHALL have exactly four states: IDLE (stable low), CHK_HI (qualifying press), HIGH (stable high), CHK_LO (qualifying release).
REQ-010 Debounce counter db_cnt SHALL be 4 bits; repeat counter rep_cnt SHALL be 6 bits; neither SHALL wrap, because both clear on reaching terminal value.
REQ-011 IDLE: s2=1 -> CHK_HI with db_cnt=0; else stay.
REQ-012 CHK_HI: s2=0 -> IDLE (bounce rejected, no pulse); s2=1 and db_cnt=DB_CYCLES-1 -> HIGH; else db_cnt+1.
REQ-013 On the CHK_HI->HIGH transition, en_pulse SHALL be 1 for exactly the following cycle, btn_level SHALL become 1, and rep_cnt SHALL clear to 0.
REQ-014 HIGH: s2=0 -> CHK_LO with db_cnt=0; else, if REP_CYCLES!=0, rep_cnt+1 each cycle; at rep_cnt=REP_CYCLES-1 -> en_pulse=1 next cycle and rep_cnt=0.
REQ-015 CHK_LO: s2=1 -> HIGH with rep_cnt=0 and no pulse; s2=0 and db_cnt=DB_CYCLES-1 -> IDLE with btn_level=0; else db_cnt+1.
REQ-016 Release SHALL never generate en_pulse.
REQ-017 en_pulse SHALL never be high on two consecutive cycles for legal parameter values.
REQ-018 Press latency SHALL be fixed: if posedge 1 is the first edge sampling btn_in=1 and btn_in stays high, en_pulse and btn_level SHALL be high in the cycle after posedge DB_CYCLES+3.
REQ-019 Release latency SHALL be symmetric: btn_level SHALL fall in the cycle after posedge DB_CYCLES+3.
REQ-020 en_pulse SHALL be driven from a posedge flop and held one full period so that a negedge-sampled downstream counter captures it exactly once.

Reset
REQ-021 While rst=1 at a posedge, the block SHALL set s1=s2=0, state=IDLE, db_cnt=0, rep_cnt=0, en_pulse=0 and btn_level=0, regardless of btn_in.
REQ-022 Reset SHALL take effect from any state, including mid-qualification and mid-repeat, with no pulse emitted on that edge.
REQ-023 If the button is still held when rst deasserts, the block SHALL treat it as a new press and pulse per REQ-018, counting from the first post-reset edge.

Verification (DB_CYCLES=8, REP_CYCLES=32 unless stated)
REQ-024 The bench SHALL cover reset: btn_in=1 with rst=1 for 3 cycles -> en_pulse=0 and btn_level=0 throughout; after release, en_pulse high in the cycle after posedge 11.
REQ-025 The bench SHALL cover a clean press: btn_in 0->1 first sampled at posedge 1 -> en_pulse high only in the cycle after posedge 11, and btn_level=1 from then on.
REQ-026 The bench SHALL cover press bounce: btn_in high 5 cycles, low 2, high 4, then low -> no en_pulse, and btn_level stays 0.
REQ-027 The bench SHALL cover auto-repeat: button held 100 cycles after HIGH entry E -> en_pulse at E, E+32, E+64 and E+96, 4 pulses total; with REP_CYCLES=0 -> 1 pulse.
REQ-028 The bench SHALL cover release bounce: in HIGH, btn_in low 3 cycles then high -> btn_level stays 1, no pulse, and the next repeat pulse arrives 32 cycles after re-entering HIGH.
REQ-029 The bench SHALL cover reset mid-repeat: rst asserted at rep_cnt=20 -> outputs 0 on the next cycle, FSM in IDLE; with the button still held, a fresh pulse per REQ-023.
